// File: rtl/diff_window_accumulator.sv
// Windowed saturating accumulator for signed difference samples with a valid/ready result port.
// Optional macro ABS_MODE_EN switches to a sum of absolute differences (positive clamp only).
module diff_window_accumulator #(
    parameter int unsigned DIFF_W = 19,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned WINDOW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DIFF_W-1:0] in_diff,
    output logic              in_ready,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              sat_flag,
    output logic              busy
);

    localparam int unsigned CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               out_valid_q, out_valid_d;
    logic               sat_q, sat_d;
    logic               busy_q, busy_d;

    logic               accept;
    logic [SUM_W-1:0]   term;
    logic [SUM_W-1:0]   sum;
    logic               ovf;
    logic [ACC_W-1:0]   acc_sat;

`ifdef ABS_MODE_EN
    logic [DIFF_W:0] diff_x;
    logic [DIFF_W:0] diff_mag;

    // Magnitude needs DIFF_W+1 bits so the most negative input is exact.
    always_comb begin
        diff_x   = {in_diff[DIFF_W-1], in_diff};
        diff_mag = diff_x[DIFF_W] ? (~diff_x + 1'b1) : diff_x;
        term     = SUM_W'(diff_mag);
    end

    always_comb begin
        sum     = {acc_q[ACC_W-1], acc_q} + term;
        ovf     = sum[SUM_W-1] != sum[SUM_W-2];
        acc_sat = ovf ? ACC_MAX : sum[ACC_W-1:0];
    end
`else
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    always_comb begin
        term    = SUM_W'($signed(in_diff));
        sum     = {acc_q[ACC_W-1], acc_q} + term;
        ovf     = sum[SUM_W-1] != sum[SUM_W-2];
        acc_sat = ovf ? (sum[SUM_W-1] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
    end
`endif

    assign in_ready = (state_q != ST_HOLD);
    assign accept   = in_valid & in_ready;

    // Next-state logic; clear aborts the window and drops any pending result.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;
        if (clear) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            acc_d       = '0;
            out_valid_d = 1'b0;
            sat_d       = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        acc_d = acc_sat;
                        sat_d = sat_q | ovf;
                        if (cnt_q == CNT_LAST) begin
                            state_d     = ST_HOLD;
                            cnt_d       = '0;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = ST_ACCUM;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_valid_q && out_ready) begin
                        state_d     = ST_IDLE;
                        cnt_d       = '0;
                        acc_d       = '0;
                        out_valid_d = 1'b0;
                        sat_d       = 1'b0;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    acc_d       = '0;
                    out_valid_d = 1'b0;
                    sat_d       = 1'b0;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;
    assign sat_flag  = sat_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_diff_window_accumulator.sv
// Bench for diff_window_accumulator: a 32-bit and a 20-bit accumulator (WINDOW=4) driven in lockstep.
module tb_diff_window_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [18:0] in_diff = '0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b1;

    logic        rdy32, ov32, sat32, busy32;
    logic [31:0] acc32;
    logic        rdy20, ov20, sat20, busy20;
    logic [19:0] acc20;

    int n_tot = 0;
    int n_bad = 0;

    logic [32:0] q32[$];
    logic [32:0] q20[$];

    typedef struct packed {
        logic [3:0][18:0] d;
        logic             bub;
        logic [31:0]      e32;
        logic             s32;
        logic [31:0]      e20;
        logic             s20;
    } vec_t;

    localparam int NV = 10;
    vec_t vt[NV];

    always #5 clk = ~clk;

    diff_window_accumulator #(.DIFF_W(19), .ACC_W(32), .WINDOW(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_diff(in_diff), .in_ready(rdy32),
        .clear(clear), .out_valid(ov32), .out_ready(out_ready), .acc_out(acc32),
        .sat_flag(sat32), .busy(busy32)
    );

    diff_window_accumulator #(.DIFF_W(19), .ACC_W(20), .WINDOW(4)) dut20 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_diff(in_diff), .in_ready(rdy20),
        .clear(clear), .out_valid(ov20), .out_ready(out_ready), .acc_out(acc20),
        .sat_flag(sat20), .busy(busy20)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [18:0] d0, input logic [18:0] d1,
                                input logic [18:0] d2, input logic [18:0] d3, input logic bub,
                                input logic [31:0] e32, input logic s32,
                                input logic [31:0] e20, input logic s20);
        vec_t v;
        v.d   = {d3, d2, d1, d0};
        v.bub = bub;
        v.e32 = e32;
        v.s32 = s32;
        v.e20 = e20;
        v.s20 = s20;
        return v;
    endfunction

    // Scoreboard: each new result (rising out_valid) pops one expected entry.
    logic ov32_prev = 1'b0;
    logic ov20_prev = 1'b0;
    always @(negedge clk) begin
        if (ov32 && !ov32_prev) begin
            if (q32.size() == 0) begin
                n_tot++; n_bad++;
                $display("FAIL res32_unexpected: got %0h want none", acc32);
            end else begin
                chk("res32", {31'b0, sat32, acc32}, {31'b0, q32.pop_front()});
            end
        end
        if (ov20 && !ov20_prev) begin
            if (q20.size() == 0) begin
                n_tot++; n_bad++;
                $display("FAIL res20_unexpected: got %0h want none", acc20);
            end else begin
                chk("res20", {31'b0, sat20, 12'b0, acc20}, {31'b0, q20.pop_front()});
            end
        end
        ov32_prev = ov32;
        ov20_prev = ov20;
    end

    task automatic apply_vec(input int i, input bit bp);
        chk("rdy_start", {rdy32, rdy20}, 2'b11);
        if (bp) out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_diff  = vt[i].d[k];
            if (k == 3) begin
                q32.push_back({vt[i].s32, vt[i].e32});
                q20.push_back({vt[i].s20, vt[i].e20});
            end
            tick();
            if (vt[i].bub && k < 3) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b0;
        if (bp) begin
            for (int h = 0; h < 5; h++) begin
                in_valid = 1'b1;
                in_diff  = 19'h63;
                tick();
                chk("hold_ov",  {ov32, ov20}, 2'b11);
                chk("hold_rdy", {rdy32, rdy20}, 2'b00);
                chk("hold_acc32", acc32, vt[i].e32);
                chk("hold_acc20", {12'b0, acc20}, vt[i].e20);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end else begin
            chk("ov_after_last", {ov32, ov20}, 2'b11);
        end
        tick();
        chk("ov_after_hs",   {ov32, ov20}, 2'b00);
        chk("busy_after_hs", {busy32, busy20}, 2'b00);
    endtask

    task automatic partial_then(input bit use_rst);
        in_valid = 1'b1;
        in_diff  = 19'd7;
        tick();
        tick();
        if (use_rst) rst = 1'b1;
        else clear = 1'b1;
        tick();
        rst      = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        chk(use_rst ? "rst_acc32" : "clr_acc32", acc32, 32'h0);
        chk(use_rst ? "rst_acc20" : "clr_acc20", {12'b0, acc20}, 32'h0);
        chk(use_rst ? "rst_busy" : "clr_busy", {busy32, busy20, ov32, ov20}, 4'b0000);
    endtask

    initial begin
        vt[0] = mk(19'd1, 19'd2, 19'd3, 19'd4, 1'b0, 32'd10, 1'b0, 32'd10, 1'b0);
        vt[1] = mk(19'h20000, 19'h20000, 19'h20000, 19'h20000, 1'b0,
                   32'd524288, 1'b0, 32'h7FFFF, 1'b1);
        vt[3] = mk(19'd5, 19'd6, 19'd7, 19'd8, 1'b0, 32'd26, 1'b0, 32'd26, 1'b0);
        vt[4] = mk(19'h3FFFF, 19'h3FFFF, 19'h3FFFF, 19'h3FFFF, 1'b0,
                   32'hFFFFC, 1'b0, 32'h7FFFF, 1'b1);
        vt[5] = mk(19'd1, 19'd1, 19'd1, 19'd1, 1'b0, 32'd4, 1'b0, 32'd4, 1'b0);
`ifdef ABS_MODE_EN
        vt[2] = mk(19'h7FFFB, 19'h7FFFB, 19'd3, 19'd0, 1'b1, 32'd13, 1'b0, 32'd13, 1'b0);
        vt[6] = mk(19'h40000, 19'h40000, 19'h40000, 19'h40000, 1'b0,
                   32'h100000, 1'b0, 32'h7FFFF, 1'b1);
        vt[7] = mk(19'h40000, 19'd0, 19'd0, 19'd0, 1'b0, 32'h40000, 1'b0, 32'h40000, 1'b0);
`else
        vt[2] = mk(19'h7FFFB, 19'h7FFFB, 19'd3, 19'd0, 1'b1,
                   32'hFFFFFFF9, 1'b0, 32'hFFFF9, 1'b0);
        vt[6] = mk(19'h40000, 19'h40000, 19'h40000, 19'h40000, 1'b0,
                   32'hFFF00000, 1'b0, 32'h80000, 1'b1);
        vt[7] = mk(19'h40000, 19'd0, 19'd0, 19'd0, 1'b0,
                   32'hFFFC0000, 1'b0, 32'hC0000, 1'b0);
`endif
        vt[8] = mk(19'd1, 19'd1, 19'd1, 19'd1, 1'b0, 32'd4, 1'b0, 32'd4, 1'b0);
        vt[9] = mk(19'd1, 19'd1, 19'd1, 19'd1, 1'b0, 32'd4, 1'b0, 32'd4, 1'b0);

        // Samples offered during reset must be dropped.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_diff  = 19'd5;
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_acc", {acc32, 12'b0, acc20}, 52'h0);
        chk("rst_flags", {ov32, sat32, busy32, ov20, sat20, busy20}, 6'b0);
        chk("rst_rdy", {rdy32, rdy20}, 2'b11);

        for (int i = 0; i < 8; i++) begin
            apply_vec(i, i == 3);
        end

        partial_then(1'b0);
        apply_vec(8, 1'b0);
        partial_then(1'b1);
        apply_vec(9, 1'b0);

        tick();
        tick();
        chk("q32_left", 64'(q32.size()), 64'h0);
        chk("q20_left", 64'(q20.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
